// File: rtl/nand4_stim_checker.sv
// rtl/nand4_stim_checker.sv - stimulus generator and response checker for a 4-input NAND cell
//
// Drives in1..in4 through all 16 vectors. After each vector it waits SETTLE_CYC
// cycles, samples qn and compares it with ~(in1&in2&in3&in4). The block reports the
// mismatch count, the first failing vector and pass/fail.
//
// Build option: define NAND4_STIM_GRAY_EN to drive the Gray code of the index.
// In that mode exactly one input toggles per step. When it is undefined, the
// vector equals the binary index.
//
// Parameters:
//   SETTLE_CYC  cycles between driving a vector and sampling qn (1..15)
//   CNT_W       settle counter width, must hold SETTLE_CYC
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start          level-sampled run request (accepted only in IDLE)
//   abort          ends a run in progress; partial results are kept
//   qn             response from the cell under test
//   in1..in4       stimulus, in1 = vector LSB, in4 = MSB
//   busy           run in progress
//   done           sticky completion flag
//   pass           valid with done, high when err_cnt == 0
//   err_cnt        mismatch count, 0..16
//   first_err_vec  driven vector of the first mismatch
//   first_err_vld  first_err_vec holds a valid value
module nand4_stim_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       qn,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       in4,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err_vec,
    output logic       first_err_vld
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       next_vec;
    logic [3:0]       drv_vec;
    logic             exp_qn;
    logic             mismatch;

`ifdef NAND4_STIM_GRAY_EN
    assign next_vec = idx ^ (idx >> 1);
`else
    assign next_vec = idx;
`endif

    // The expected response comes from the registered vector actually on the
    // pins. This keeps the check correct in both the binary and the Gray build.
    assign drv_vec  = {in4, in3, in2, in1};
    assign exp_qn   = ~(&drv_vec);
    // Case-inequality makes an X or Z on qn count as a failure.
    assign mismatch = (qn !== exp_qn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 4'd0;
            cnt           <= '0;
            {in4, in3, in2, in1} <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= 5'd0;
            first_err_vec <= 4'd0;
            first_err_vld <= 1'b0;
        end else if (busy && abort) begin
            // The results gathered so far are kept on purpose. done stays low,
            // so the run is not reported as complete.
            state                <= IDLE;
            {in4, in3, in2, in1} <= 4'd0;
            busy                 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        err_cnt       <= 5'd0;
                        first_err_vec <= 4'd0;
                        first_err_vld <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        idx           <= 4'd0;
                        busy          <= 1'b1;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    {in4, in3, in2, in1} <= next_vec;
                    cnt                  <= CNT_LOAD;
                    state                <= SETTLE;
                end
                SETTLE: begin
                    // The counter is loaded with SETTLE_CYC-1. The state moves
                    // on at the edge where it reads 0, which gives a settle time
                    // of exactly SETTLE_CYC cycles.
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 5'd1;
                        if (!first_err_vld) begin
                            first_err_vec <= drv_vec;
                            first_err_vld <= 1'b1;
                        end
                    end
                    if (idx == 4'd15) begin
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= DRIVE;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    // The last sample's increment has already been applied here.
                    pass  <= (err_cnt == 5'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand4_stim_checker.sv
// tb/tb_nand4_stim_checker.sv - self-checking bench for nand4_stim_checker
`define CHK(tag, obs, exp) \
    begin \
        n_assert++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_nand4_stim_checker;

    localparam int S     = 2;
    localparam int P     = S + 2;
    localparam int DONE_AT = 16 * P + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       qn;
    logic       in1, in2, in3, in4;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] first_err_vec;
    logic       first_err_vld;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          mode;       // 0: good cell ^ mask, 1: stuck-at-1, 2: stuck-at-0
    logic [15:0] mask;       // per driven vector value, 1 = corrupt response

    always #5 clk = ~clk;

    nand4_stim_checker #(.SETTLE_CYC(S), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .qn(qn),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_vld(first_err_vld)
    );

    // Cell model: an ideal NAND4 with optional faults.
    always_comb begin
        case (mode)
            1:       qn = 1'b1;
            2:       qn = 1'b0;
            default: qn = ~(in1 & in2 & in3 & in4) ^ mask[{in4, in3, in2, in1}];
        endcase
    end

    function automatic logic [3:0] vec_of(input int i);
        logic [3:0] b;
        b = 4'(i);
`ifdef NAND4_STIM_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    function automatic logic cell_resp(input logic [3:0] v);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (v != 4'hF) ^ mask[v];
    endfunction

    // Run one full sweep and check the sequence, timing and final results
    // against the reference model.
    task automatic do_run(input int m, input logic [15:0] msk, input string tag);
        int          exp_err;
        logic        exp_vld;
        logic [3:0]  exp_first;
        int          n;
        int          done_n;
        int          busy_low_n;
        logic [3:0]  v;
        mode = m;
        mask = msk;
        exp_err = 0; exp_vld = 0; exp_first = 0;
        for (int i = 0; i < 16; i++) begin
            v = vec_of(i);
            if (cell_resp(v) != (v != 4'hF)) begin
                exp_err++;
                if (!exp_vld) begin exp_vld = 1; exp_first = v; end
            end
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 1 - 1;
        done_n = -1; busy_low_n = -1;
        `CHK({tag, "_busy_rise"}, busy, 1'b1)
        while (done_n < 0 && n < 200) begin
            @(negedge clk); n++;
            if (n % P == 2 && n / P < 16) begin
                v = vec_of(n / P);
                `CHK({tag, "_vec"}, {in4, in3, in2, in1}, v)
            end
            if (!busy && busy_low_n < 0) busy_low_n = n;
            if (done) done_n = n;
        end
        `CHK({tag, "_busy_len"}, busy_low_n, 16 * P)
        `CHK({tag, "_done_at"}, done_n, DONE_AT)
        `CHK({tag, "_err_cnt"}, err_cnt, 5'(exp_err))
        `CHK({tag, "_first_vld"}, first_err_vld, exp_vld)
        `CHK({tag, "_first_vec"}, first_err_vec, exp_first)
        `CHK({tag, "_pass"}, pass, (exp_err == 0))
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; mask = 16'h0;
        repeat (2) @(negedge clk);
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_in", {in4, in3, in2, in1}, 4'h0)
        `CHK("rst_err", err_cnt, 5'd0)
        rst = 1'b0;

        // start and abort together: abort wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        `CHK("start_abort_idle", busy, 1'b0)

        do_run(0, 16'h0000, "good");
        do_run(1, 16'h0000, "stuck1");
        do_run(2, 16'h0000, "stuck0");
        `CHK("done_sticky", done, 1'b1)
        for (int r = 0; r < 3; r++) do_run(0, 16'($urandom), "rand");

        // abort during vector 5 settle, qn stuck at 0
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5 * P + 1) @(negedge clk);
        `CHK("ab_pre_vec", {in4, in3, in2, in1}, vec_of(5))
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        `CHK("ab_busy", busy, 1'b0)
        `CHK("ab_in", {in4, in3, in2, in1}, 4'h0)
        `CHK("ab_done", done, 1'b0)
        `CHK("ab_err", err_cnt, 5'd5)
        `CHK("ab_first", {first_err_vld, first_err_vec}, {1'b1, vec_of(0)})
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        `CHK("ab_restart_clr", err_cnt, 5'd0)
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;

        // asynchronous reset at vector 9, between edges
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9 * P + 1) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        `CHK("arst_busy", busy, 1'b0)
        `CHK("arst_in", {in4, in3, in2, in1}, 4'h0)
        `CHK("arst_res", {done, pass, err_cnt, first_err_vec, first_err_vld}, 12'h0)
        @(negedge clk); rst = 1'b0;
        do_run(0, 16'h0000, "post_rst");

        // start held high: a new run begins one edge after FINISH
        mode = 0; mask = 16'h0;
        @(negedge clk); start = 1'b1;
        repeat (DONE_AT + 1) @(negedge clk);
        `CHK("hold_done", done, 1'b1)
        @(negedge clk);
        `CHK("hold_restart_busy", busy, 1'b1)
        `CHK("hold_restart_done", done, 1'b0)
        start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nand4_stim_checker.md
Name: nand4_stim_checker

Overview:
- Sequential stimulus generator and response checker for a 4-input NAND cell with ports IN1..IN4 and QN.
- The block drives IN1..IN4 through all 16 input vectors, waits a programmable settle interval, samples QN and compares it with the expected value ~(IN1&IN2&IN3&IN4).
- It sits in the cell-library verification harness beside the instantiated gate and reports the mismatch count, the first failing vector and pass/fail.

Parameters:
- SETTLE_CYC, 2, number of CLK cycles between driving a vector and sampling QN; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYC.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  level-sampled request to begin a 16-vector run.
- ABORT  input  1  terminates a run in progress.
- QN  input  1  response from the cell under test.
- IN1  output  1  stimulus bit 0 (LSB of the vector).
- IN2  output  1  stimulus bit 1.
- IN3  output  1  stimulus bit 2.
- IN4  output  1  stimulus bit 3 (MSB).
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  sticky completion flag.
- PASS  output  1  valid when DONE=1; high when ERR_CNT=0.
- ERR_CNT  output  5  mismatch count, range 0..16.
- FIRST_ERR_VEC  output  4  vector index of the first mismatch.
- FIRST_ERR_VLD  output  1  FIRST_ERR_VEC holds a valid value.

Behaviour:
- Reset values (RST=1, asynchronous): state IDLE; IN1..IN4=0; BUSY=0; DONE=0; PASS=0; ERR_CNT=0; FIRST_ERR_VEC=0; FIRST_ERR_VLD=0; vector index=0; settle counter=0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - START=1 and ABORT=0 at an edge: clear ERR_CNT, FIRST_ERR_*, DONE and PASS; set vector index=0; go to DRIVE; BUSY=1 from the next cycle.
  - START=1 and ABORT=1 together: ABORT wins; remain in IDLE.
- DRIVE (1 cycle): register {IN4,IN3,IN2,IN1} = current vector; load the settle counter with SETTLE_CYC-1; go to SETTLE.
- SETTLE: hold the inputs stable; decrement the counter; at 0 go to SAMPLE. Duration is exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - Compare QN with the expected value using case-inequality, so X or Z on QN counts as a mismatch.
  - On mismatch: ERR_CNT += 1. If FIRST_ERR_VLD=0, capture the vector index into FIRST_ERR_VEC and set FIRST_ERR_VLD.
  - Index 15: go to FINISH. Otherwise increment the index and go to DRIVE.
- FINISH (1 cycle): BUSY=0; DONE=1; PASS=(ERR_CNT==0); go to IDLE.
- DONE, PASS, ERR_CNT and FIRST_ERR_* hold their values until the next accepted START or RST.
- Timing:
  - Run length per vector is SETTLE_CYC+2 cycles.
  - DONE rises 16*(SETTLE_CYC+2)+1 cycles after the START-accept edge: 65 cycles with default SETTLE_CYC=2.
- Expected response: 1 for vectors 0..14; 0 for vector 15.
- START while BUSY=1 is ignored. Holding START high continuously restarts a run on the first edge in IDLE after FINISH.
- ABORT while BUSY=1: go to IDLE next edge; IN1..IN4 return to 0; BUSY=0; DONE stays 0; partial ERR_CNT and FIRST_ERR_* are retained.
- ERR_CNT cannot exceed 16; no saturation logic is needed.
- RST asserted mid-run: all outputs take their reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro NAND4_STIM_GRAY_EN.
- Defined: the driven vector is the Gray code of the index (idx ^ (idx>>1)), so exactly one input toggles per step and each timing arc is exercised in isolation. Expected QN is computed from the driven Gray vector. FIRST_ERR_VEC reports the driven vector, not the index.
- Undefined: the driven vector equals the binary index 0..15.

Test Plan:
- Fault-free NAND4 model, SETTLE_CYC=2, pulse START -> BUSY high for 64 cycles, DONE=1 at cycle 65, PASS=1, ERR_CNT=0, FIRST_ERR_VLD=0.
- QN forced to constant 1 -> ERR_CNT=1, FIRST_ERR_VEC=15, PASS=0.
- QN forced to constant 0 -> ERR_CNT=15, FIRST_ERR_VEC=0, PASS=0; the vector sequence on IN4..IN1 matches 0..15.
- ABORT pulsed during vector 5 SETTLE with QN stuck 0 -> IDLE next cycle, IN1..IN4=0, DONE=0, ERR_CNT=5; a following START clears ERR_CNT to 0.
- RST asserted at vector 9 between clock edges -> all outputs at reset values before the next edge; START after release runs a complete 16-vector sweep.
- NAND4_STIM_GRAY_EN defined, cell delay 1 cycle, SETTLE_CYC=1 -> exactly one IN bit changes per DRIVE, PASS=1; a QN stuck-at-1 fault -> FIRST_ERR_VEC=4'b1111 (index 10).
